// File: rtl/mc_serial_deserializer_pkg.sv
// Shared types and width helpers for the multi-channel serial deserializer.
package serdes_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_ERR
  } serdes_state_t;

  localparam int ERR_CNT_W = 16;

  // Counter width for a modulus of n, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mc_serial_deserializer_word_out_reg.sv
// Single-entry valid/ready holding register; loads land the edge after load_vld (1 cycle).
// A load in the same cycle as a drain wins, so the consumer sees back-to-back words with no bubble.
module word_out_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load_vld,
  input  logic [WIDTH-1:0] load_dat,
  output logic             word_vld,
  input  logic             word_rdy,
  output logic [WIDTH-1:0] word_dat
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      word_vld <= 1'b0;
      word_dat <= '0;
    end else if (en) begin
      if (load_vld) begin
        word_vld <= 1'b1;
        word_dat <= load_dat;
      end else if (word_vld && word_rdy) begin
        word_vld <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/mc_serial_deserializer.sv
// TDM bit-serial to parallel word deserializer with frame sync checking; word valid 1 cycle after its last bit.
// Under output backpressure only the completing bit is stalled; partial words keep shifting.
module mc_serial_deserializer
  import serdes_pkg::*;
#(
  parameter int DATA_WIDTH   = 24,
  parameter int NUM_CHANNELS = 8,
  parameter int MSB_FIRST    = 0,
  parameter int ABORT_ON_GAP = 0,
  localparam int CW = cnt_width(NUM_CHANNELS)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_en,
  input  logic                  i_din,
  input  logic                  i_din_valid,
  input  logic                  i_sync,
  output logic                  o_ready,
  output logic [DATA_WIDTH-1:0] o_word,
  output logic [CW-1:0]         o_chan,
  output logic                  o_word_valid,
  input  logic                  i_word_ready,
  output logic                  o_frame_err,
  output logic [ERR_CNT_W-1:0]  o_err_count
);

  localparam int BW = cnt_width(DATA_WIDTH);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_WIDTH - 1);
  localparam logic [CW-1:0] LAST_CHAN = CW'(NUM_CHANNELS - 1);

  serdes_state_t         state_q, state_d;
  logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [CW-1:0]         chan_cnt_q, chan_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d, shift_in;
  logic                  err_d;
  logic                  load_vld;
  logic                  accept;
  logic [DATA_WIDTH+CW-1:0] word_dat;

  assign o_ready = i_rst_n & i_en &
                   ~(o_word_valid & ~i_word_ready & (bit_cnt_q == LAST_BIT));
  assign accept  = i_en & i_din_valid & o_ready;

  always_comb begin
    shift_in = '0;
    if (MSB_FIRST != 0) shift_in = {shift_q[DATA_WIDTH-2:0], i_din};
    else                shift_in = {i_din, shift_q[DATA_WIDTH-1:1]};
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    chan_cnt_d = chan_cnt_q;
    shift_d    = shift_q;
    err_d      = 1'b0;
    load_vld   = 1'b0;
    if (i_en) begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            shift_d    = shift_in;
            bit_cnt_d  = BW'(1);
            state_d    = S_SHIFT;
            chan_cnt_d = i_sync ? '0 : chan_cnt_q;
            err_d      = i_sync && (chan_cnt_q != '0);
          end
        end
        S_SHIFT: begin
          if (accept) begin
            shift_d = shift_in;
            if (i_sync) begin
              // Restart framing: this bit opens channel 0, the partial word is dropped.
              err_d      = 1'b1;
              chan_cnt_d = '0;
              bit_cnt_d  = BW'(1);
            end else if (bit_cnt_q == LAST_BIT) begin
              load_vld   = 1'b1;
              bit_cnt_d  = '0;
              chan_cnt_d = (chan_cnt_q == LAST_CHAN) ? '0 : chan_cnt_q + 1'b1;
              state_d    = S_IDLE;
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end else if ((ABORT_ON_GAP != 0) && !i_din_valid) begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end
        end
        S_ERR: begin
          state_d   = S_IDLE;
          bit_cnt_d = '0;
          shift_d   = '0;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      bit_cnt_q   <= '0;
      chan_cnt_q  <= '0;
      shift_q     <= '0;
      o_frame_err <= 1'b0;
      o_err_count <= '0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      chan_cnt_q  <= chan_cnt_d;
      shift_q     <= shift_d;
      o_frame_err <= err_d;
      if (err_d && (o_err_count != '1)) o_err_count <= o_err_count + 1'b1;
    end
  end

  word_out_reg #(
    .WIDTH(DATA_WIDTH + CW)
  ) u_word_out (
    .clk      (i_clk),
    .rst_n    (i_rst_n),
    .en       (i_en),
    .load_vld (load_vld),
    .load_dat ({shift_in, chan_cnt_q}),
    .word_vld (o_word_valid),
    .word_rdy (i_word_ready),
    .word_dat (word_dat)
  );

  assign o_word = word_dat[CW +: DATA_WIDTH];
  assign o_chan = word_dat[CW-1:0];

endmodule

// File: tb/tb_mc_serial_deserializer.sv
// Directed bench: LSB-first, MSB-first and gap-abort instances share one stimulus stream.
module tb_mc_serial_deserializer;
  import serdes_pkg::*;

  localparam int DW = 24;
  localparam int NC = 4;

  localparam logic [DW-1:0] W0  = 24'h5AA501;
  localparam logic [DW-1:0] W1  = 24'h800001;
  localparam logic [DW-1:0] W2  = 24'hFFFFFE;
  localparam logic [DW-1:0] W3  = 24'h000000;
  localparam logic [DW-1:0] W4  = 24'h123456;
  localparam logic [DW-1:0] W5  = 24'hABCDEF;
  localparam logic [DW-1:0] W6  = 24'h3C3C3C;
  localparam logic [DW-1:0] W7  = 24'h0F0F0F;
  localparam logic [DW-1:0] W8  = 24'h00C3A5;
  localparam logic [DW-1:0] W9  = 24'h777777;
  localparam logic [DW-1:0] W10 = 24'h13579B;

  logic tb_clk;
  logic rst_n, en, din_l, din_m, din_valid, sync, word_ready;

  logic          ready_l, ready_m, ready_g;
  logic [DW-1:0] word_l, word_m, word_g;
  logic [1:0]    chan_l, chan_m, chan_g;
  logic          wv_l, wv_m, wv_g;
  logic          ferr_l, ferr_m, ferr_g;
  logic [15:0]   ecnt_l, ecnt_m, ecnt_g;

  int checks = 0;
  int errors = 0;

  logic [DW+1:0] q_l[$];
  logic [DW+1:0] q_m[$];

  mc_serial_deserializer #(.DATA_WIDTH(DW), .NUM_CHANNELS(NC), .MSB_FIRST(0), .ABORT_ON_GAP(0)) u_lsb (
    .i_clk(tb_clk), .i_rst_n(rst_n), .i_en(en), .i_din(din_l), .i_din_valid(din_valid),
    .i_sync(sync), .o_ready(ready_l), .o_word(word_l), .o_chan(chan_l), .o_word_valid(wv_l),
    .i_word_ready(word_ready), .o_frame_err(ferr_l), .o_err_count(ecnt_l));

  mc_serial_deserializer #(.DATA_WIDTH(DW), .NUM_CHANNELS(NC), .MSB_FIRST(1), .ABORT_ON_GAP(0)) u_msb (
    .i_clk(tb_clk), .i_rst_n(rst_n), .i_en(en), .i_din(din_m), .i_din_valid(din_valid),
    .i_sync(sync), .o_ready(ready_m), .o_word(word_m), .o_chan(chan_m), .o_word_valid(wv_m),
    .i_word_ready(word_ready), .o_frame_err(ferr_m), .o_err_count(ecnt_m));

  mc_serial_deserializer #(.DATA_WIDTH(DW), .NUM_CHANNELS(NC), .MSB_FIRST(0), .ABORT_ON_GAP(1)) u_gap (
    .i_clk(tb_clk), .i_rst_n(rst_n), .i_en(en), .i_din(din_l), .i_din_valid(din_valid),
    .i_sync(sync), .o_ready(ready_g), .o_word(word_g), .o_chan(chan_g), .o_word_valid(wv_g),
    .i_word_ready(word_ready), .o_frame_err(ferr_g), .o_err_count(ecnt_g));

  initial tb_clk = 1'b0;
  always #5 tb_clk = ~tb_clk;

  always @(negedge tb_clk) begin
    if (wv_l && word_ready) q_l.push_back({chan_l, word_l});
    if (wv_m && word_ready) q_m.push_back({chan_m, word_m});
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic set_bit(input logic [DW-1:0] w, input int i, input logic s);
    din_l     = w[i];
    din_m     = w[DW-1-i];
    sync      = s;
    din_valid = 1'b1;
  endtask

  task automatic put_bit(input logic [DW-1:0] w, input int i, input logic s);
    logic ok;
    set_bit(w, i, s);
    ok = 1'b0;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(negedge tb_clk);
      ok = ready_l;
    end
    if (!ok) chk("ready_timeout", 32'(ok), 32'd1);
    @(posedge tb_clk);
    #1;
  endtask

  task automatic send_range(input logic [DW-1:0] w, input int lo, input int hi, input logic s0);
    for (int i = lo; i <= hi; i++) put_bit(w, i, s0 && (i == lo));
  endtask

  task automatic idle();
    din_valid = 1'b0;
    sync      = 1'b0;
  endtask

  task automatic step();
    @(posedge tb_clk);
    #1;
  endtask

  task automatic expect_word(input logic [DW-1:0] w, input logic [1:0] c);
    chk("valid_l", 32'(wv_l), 32'd1);
    chk("word_l", 32'(word_l), 32'(w));
    chk("chan_l", 32'(chan_l), 32'(c));
    chk("valid_m", 32'(wv_m), 32'd1);
    chk("word_m", 32'(word_m), 32'(w));
    chk("chan_m", 32'(chan_m), 32'(c));
  endtask

  task automatic expect_reset_outputs(input string tag);
    chk({tag, "_valid"}, 32'(wv_l), 32'd0);
    chk({tag, "_word"}, 32'(word_l), 32'd0);
    chk({tag, "_chan"}, 32'(chan_l), 32'd0);
    chk({tag, "_ferr"}, 32'(ferr_l), 32'd0);
    chk({tag, "_ecnt"}, 32'(ecnt_l), 32'd0);
    chk({tag, "_ready"}, 32'(ready_l), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] ew[9];
    logic [1:0]    ec[9];
    ew = '{W0, W1, W2, W3, W4, W5, W7, W8, W10};
    ec = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd0, 2'd1, 2'd0};

    rst_n = 1'b0; en = 1'b0; din_l = 1'b0; din_m = 1'b0;
    din_valid = 1'b0; sync = 1'b0; word_ready = 1'b1;

    // Reset and release
    repeat (3) step();
    expect_reset_outputs("rst");
    rst_n = 1'b1;
    step();
    expect_reset_outputs("post_rst");
    en = 1'b1;
    #1;
    chk("ready_en", 32'(ready_l), 32'd1);

    // Round trip, both bit orders, back to back
    send_range(W0, 0, DW-1, 1'b1); expect_word(W0, 2'd0);
    send_range(W1, 0, DW-1, 1'b0); expect_word(W1, 2'd1);
    send_range(W2, 0, DW-1, 1'b0); expect_word(W2, 2'd2);
    send_range(W3, 0, DW-1, 1'b0); expect_word(W3, 2'd3);
    chk("no_err_trip_l", 32'(ecnt_l), 32'd0);
    chk("no_err_trip_m", 32'(ecnt_m), 32'd0);
    idle();
    step();

    // Backpressure across two completions
    word_ready = 1'b0;
    send_range(W4, 0, DW-1, 1'b0); expect_word(W4, 2'd0);
    send_range(W5, 0, 21, 1'b0);
    chk("bp_ready_bit22", 32'(ready_l), 32'd1);
    send_range(W5, 22, 22, 1'b0);
    chk("bp_ready_bit23", 32'(ready_l), 32'd0);
    set_bit(W5, DW-1, 1'b0);
    repeat (3) step();
    chk("bp_hold_word", 32'(word_l), 32'(W4));
    chk("bp_hold_chan", 32'(chan_l), 32'd0);
    chk("bp_hold_valid", 32'(wv_l), 32'd1);
    chk("bp_stall_ready", 32'(ready_l), 32'd0);
    word_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(ready_l), 32'd1);
    @(posedge tb_clk);
    #1;
    expect_word(W5, 2'd1);

    // Sync on bit 10 of channel 2
    send_range(W6, 0, 9, 1'b0);
    send_range(W7, 0, 0, 1'b1);
    chk("msync_ferr_l", 32'(ferr_l), 32'd1);
    chk("msync_ecnt_l", 32'(ecnt_l), 32'd1);
    chk("msync_ferr_m", 32'(ferr_m), 32'd1);
    send_range(W7, 1, 1, 1'b0);
    chk("msync_pulse_len", 32'(ferr_l), 32'd0);
    send_range(W7, 2, DW-1, 1'b0);
    expect_word(W7, 2'd0);

    // Gap after bit 5: aborts only the ABORT_ON_GAP instance
    send_range(W8, 0, 5, 1'b0);
    idle();
    step();
    chk("gap_ferr_g", 32'(ferr_g), 32'd1);
    chk("gap_state_g", 32'(u_gap.state_q), 32'(S_ERR));
    chk("gap_ferr_l", 32'(ferr_l), 32'd0);
    step();
    chk("gap_idle_g", 32'(u_gap.state_q), 32'(S_IDLE));
    chk("gap_chan_g", 32'(u_gap.chan_cnt_q), 32'd1);
    chk("gap_ecnt_g", 32'(ecnt_g), 32'd2);
    send_range(W8, 6, DW-1, 1'b0);
    expect_word(W8, 2'd1);
    chk("gap_noword_g", 32'(wv_g), 32'd0);
    chk("gap_ecnt_l", 32'(ecnt_l), 32'd1);
    idle();
    step();

    // Reset mid-word with a pending output word
    word_ready = 1'b0;
    send_range(W9, 0, DW-1, 1'b0);
    chk("pend_valid", 32'(wv_l), 32'd1);
    send_range(W10, 0, 6, 1'b0);
    rst_n = 1'b0;
    idle();
    step();
    chk("mrst_valid", 32'(wv_l), 32'd0);
    chk("mrst_ferr", 32'(ferr_l), 32'd0);
    chk("mrst_ecnt", 32'(ecnt_l), 32'd0);
    chk("mrst_ready", 32'(ready_l), 32'd0);
    rst_n = 1'b1;
    word_ready = 1'b1;
    send_range(W10, 0, DW-1, 1'b0);
    expect_word(W10, 2'd0);
    idle();
    step();

    // Error counter saturation: sync on every bit
    din_l = 1'b0; din_m = 1'b0; sync = 1'b1; din_valid = 1'b1;
    repeat (100) step();
    chk("sat_cnt_100", 32'(ecnt_l), 32'd100);
    chk("sat_ferr", 32'(ferr_l), 32'd1);
    repeat (65440) step();
    chk("sat_cnt_l", 32'(ecnt_l), 32'h0000FFFF);
    chk("sat_cnt_g", 32'(ecnt_g), 32'h0000FFFF);
    repeat (5) step();
    chk("sat_hold_l", 32'(ecnt_l), 32'h0000FFFF);
    idle();
    step();

    // Delivered word order and content
    chk("sb_size_l", 32'(q_l.size()), 32'd9);
    chk("sb_size_m", 32'(q_m.size()), 32'd9);
    for (int i = 0; i < 9; i++) begin
      if (i < q_l.size()) chk("sb_l", 32'(q_l[i]), 32'({ec[i], ew[i]}));
      if (i < q_m.size()) chk("sb_m", 32'(q_m[i]), 32'({ec[i], ew[i]}));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mc_serial_deserializer.md
# mc_serial_deserializer

Parametrised multi-channel successor to the FIR front-end deserializer. It accepts a bit-serial, time-division-multiplexed stream of `NUM_CHANNELS` interleaved words and assembles each `DATA_WIDTH`-bit word. Each word is emitted with its channel index on a valid/ready parallel port. It adds three behaviours: selectable bit order, frame synchronisation with error detection, and output backpressure. It sits between the serial input pins and the per-channel FIR pipelines.

## Interface
- `DATA_WIDTH`, 24, bits per word
- `NUM_CHANNELS`, 8, words per frame; ≥1
- `MSB_FIRST`, 0, 0 = LSB arrives first, 1 = MSB arrives first
- `ABORT_ON_GAP`, 0, 1 = `i_din_valid` low mid-word is a frame error
- `i_clk  in  1  sole clock, rising edge`
- `i_rst_n  in  1  reset, synchronous, active-low`
- `i_en  in  1  block enable; low freezes all state, o_ready low`
- `i_din  in  1  serial data bit`
- `i_din_valid  in  1  i_din valid this cycle`
- `i_sync  in  1  marks bit 0 of channel 0 (frame start); sampled only with an accepted bit`
- `o_ready  out  1  bit accepted when i_en & i_din_valid & o_ready`
- `o_word  out  DATA_WIDTH  assembled word`
- `o_chan  out  $clog2(NUM_CHANNELS) (min 1)  channel of o_word`
- `o_word_valid  out  1  o_word/o_chan valid`
- `i_word_ready  in  1  consumer accepts o_word when high with o_word_valid`
- `o_frame_err  out  1  one-cycle pulse per detected error`
- `o_err_count  out  16  saturating error count`

## Operation
- FSM states:
  - S_IDLE: bit_cnt = 0, no partial word.
  - S_SHIFT: 1 ≤ bit_cnt ≤ DATA_WIDTH-1.
  - S_ERR: one cycle; discards the partial word, then returns to S_IDLE.
- Accepted bit insertion:
  - MSB_FIRST = 0: shift right, new bit enters at bit DATA_WIDTH-1.
  - MSB_FIRST = 1: shift left, new bit enters at bit 0.
- Word completion: on the bit where bit_cnt = DATA_WIDTH-1, load {shift_reg + bit, chan_cnt} into the output register. Then reset bit_cnt to 0 and go to S_IDLE. chan_cnt increments and wraps NUM_CHANNELS-1 → 0.
- `i_sync` on an accepted bit in S_IDLE forces chan_cnt = 0 for that word. If chan_cnt was not already 0, that is a frame error: pulse o_frame_err, but the word is still assembled as channel 0.
- `i_sync` on an accepted bit in S_SHIFT is a frame error:
  - The partial word is discarded.
  - The sync bit becomes bit 0 of channel 0.
  - No S_ERR cycle is taken; the FSM stays in S_SHIFT with bit_cnt = 1.
- Gap errors apply only when ABORT_ON_GAP = 1. A cycle in S_SHIFT with i_en = 1 and i_din_valid = 0 → S_ERR, o_frame_err pulse, chan_cnt unchanged. With ABORT_ON_GAP = 0, gaps are ignored.
- o_err_count increments on every o_frame_err pulse and saturates at 16'hFFFF.
- The output register is a single entry. It clears when o_word_valid & i_word_ready, unless a new word loads in the same cycle; load wins, so valid stays 1.
- o_ready = i_en & ~(o_word_valid & ~i_word_ready & bit_cnt == DATA_WIDTH-1). Only the completing bit is stalled, so partial shifting continues under backpressure.
- `i_en` = 0: no state changes and no errors; outputs hold.

## Timing
- Reset (i_rst_n low at a rising edge) drives:
  - o_word = 0, o_chan = 0, o_word_valid = 0, o_frame_err = 0, o_err_count = 0, o_ready = 0.
  - FSM = S_IDLE, bit_cnt = 0, chan_cnt = 0.
- Reset mid-word discards the partial word and any pending output word, without an error pulse.
- Latency: o_word_valid rises on the edge after the last bit is accepted, i.e. 1 cycle.
- Throughput: one bit per cycle, one word per DATA_WIDTH cycles, with no dead cycle between words.
- o_word and o_chan are stable while o_word_valid & ~i_word_ready.
- o_frame_err is registered: it is high the cycle after the offending bit or gap.
- Simultaneous drain and load in one cycle: the new word appears with no bubble.

## Structure
- Package `serdes_pkg`: the state enum `serdes_state_t` {S_IDLE, S_SHIFT, S_ERR}, and localparam helpers for counter widths (`$clog2(DATA_WIDTH)`, channel width with min 1).
- One sub-module, `word_out_reg`: a single-entry valid/ready holding register, parametrised on payload width, with load-over-drain priority.
- The remainder (FSM, shift register, counters) lives in the top file.

## Test plan
- Reset/idle: while i_rst_n = 0, and on the first cycle after release, all outputs read 0 and o_ready = 0. Then raise i_en → o_ready = 1.
- LSB-first round trip: DATA_WIDTH = 24, NUM_CHANNELS = 4, words 24'h5A_A5_01, 24'h80_00_01, 24'hFF_FF_FE, 24'h00_00_00, with i_sync on the first bit.
  - Expect o_chan 0, 1, 2, 3, matching words, valid 1 cycle after each last bit.
  - Repeat with MSB_FIRST = 1.
- Backpressure: hold i_word_ready = 0 across two word completions.
  - o_ready drops only on bit 23 of the second word.
  - The first word is held stable.
  - On release, both words arrive in order with no loss.
- Mid-word sync: assert i_sync on bit 10 of channel 2.
  - Expect o_frame_err pulse and o_err_count = 1.
  - The next word emitted is channel 0, built from the sync bit onward.
- Gap abort: with ABORT_ON_GAP = 1, drop i_din_valid after bit 5.
  - Expect S_ERR, o_frame_err, no word emitted, and chan_cnt unchanged.
  - With ABORT_ON_GAP = 0, the same stimulus yields the correct word and no error.
- Saturation: force 65 537 errors → o_err_count stays at 16'hFFFF.
